// File: rtl/riscv_pkg.sv
// RV32I base-ISA encodings shared by the decode pipeline: opcode map,
// instruction formats, decoded-field bundle and small decode helpers.
package riscv_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'h03,
      OPC_MISC_MEM = 7'h0F,
      OPC_OP_IMM   = 7'h13,
      OPC_AUIPC    = 7'h17,
      OPC_STORE    = 7'h23,
      OPC_OP       = 7'h33,
      OPC_LUI      = 7'h37,
      OPC_BRANCH   = 7'h63,
      OPC_JALR     = 7'h67,
      OPC_JAL      = 7'h6F,
      OPC_SYSTEM   = 7'h73
   } opcode_e;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // Opcode is kept raw so unknown encodings still flow through the pipe.
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      logic [6:0] funct7;
      fmt_e       fmt;
   } decoded_instr_t;

   function automatic fmt_e opcode_fmt(input logic [6:0] opc);
      fmt_e f;
      case (opc)
         OPC_LUI, OPC_AUIPC:                  f = FMT_U;
         OPC_JAL:                             f = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM,
         OPC_MISC_MEM, OPC_SYSTEM:            f = FMT_I;
         OPC_STORE:                           f = FMT_S;
         OPC_BRANCH:                          f = FMT_B;
         default:                             f = FMT_R;
      endcase
      return f;
   endfunction

   function automatic logic opcode_legal(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: ok = 1'b1;
         default:                                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic fmt_uses_rs1(input fmt_e f);
      return !((f == FMT_U) || (f == FMT_J));
   endfunction

   function automatic logic fmt_uses_rs2(input fmt_e f);
      return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
   endfunction

   function automatic decoded_instr_t decode_fields(input logic [31:0] instr);
      decoded_instr_t d;
      d.opcode = instr[6:0];
      d.rd     = instr[11:7];
      d.funct3 = instr[14:12];
      d.rs1    = instr[19:15];
      d.rs2    = instr[24:20];
      d.funct7 = instr[31:25];
      d.fmt    = opcode_fmt(instr[6:0]);
      return d;
   endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master: the surrounding pipeline (fetch producer / execute consumer).
// slave:  the decode stage itself.
interface decode_pipe_if #(
   parameter int unsigned XLEN = 32
);
   import riscv_pkg::*;

   logic            fd_valid;
   logic            fd_ready;
   logic [31:0]     fd_instr;
   logic [XLEN-1:0] fd_pc;

   logic            de_valid;
   logic            de_ready;
   decoded_instr_t  de_decoded;
   logic [XLEN-1:0] de_pc;
   logic [XLEN-1:0] de_rs1_val;
   logic [XLEN-1:0] de_rs2_val;
   logic [XLEN-1:0] de_imm;
   logic            de_illegal;

   modport master (
      output fd_valid, fd_instr, fd_pc, de_ready,
      input  fd_ready, de_valid, de_decoded, de_pc, de_rs1_val, de_rs2_val,
             de_imm, de_illegal
   );

   modport slave (
      input  fd_valid, fd_instr, fd_pc, de_ready,
      output fd_ready, de_valid, de_decoded, de_pc, de_rs1_val, de_rs2_val,
             de_imm, de_illegal
   );
endinterface

// File: rtl/imm_gen.sv
// Immediate extraction for RV32I formats, sign-extended to XLEN.
// R-type and unknown opcodes yield zero.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;

   // Reassemble the immediate bits according to the opcode's format
   always_comb begin
      w_imm32 = '0;
      case (opcode_fmt(i_instr[6:0]))
         FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
         FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: small instruction queue, combinational decode of the queue
// head with register-file read, and a registered output stage. Load-use
// hazards against the instruction in the output stage insert one bubble.
module decode_pipe
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned QDEPTH    = 2,
   parameter bit          HAZARD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   decode_pipe_if.slave     bus,
   input  logic             flush,
   output logic [4:0]       rf_rs1_addr,
   output logic [4:0]       rf_rs2_addr,
   input  logic [XLEN-1:0]  rf_rs1_data,
   input  logic [XLEN-1:0]  rf_rs2_data,
   output logic [15:0]      stall_count
);

   localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

   logic [31:0]      r_instr_mem [QDEPTH];
   logic [XLEN-1:0]  r_pc_mem    [QDEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             r_de_valid;
   decoded_instr_t   r_de_decoded;
   logic [XLEN-1:0]  r_de_pc;
   logic [XLEN-1:0]  r_de_rs1_val;
   logic [XLEN-1:0]  r_de_rs2_val;
   logic [XLEN-1:0]  r_de_imm;
   logic             r_de_illegal;
   logic [15:0]      r_stall_count;

   logic             w_fd_ready;
   logic             w_push;
   logic             w_head_valid;
   logic [31:0]      w_head_instr;
   logic [XLEN-1:0]  w_head_pc;
   decoded_instr_t   w_head;
   logic [XLEN-1:0]  w_head_imm;
   logic             w_hazard;
   logic             w_advance;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full queue refuses fetch even when the head pops in the same cycle.
   assign w_fd_ready   = (r_count != CNT_W'(QDEPTH));
   assign w_push       = bus.fd_valid && w_fd_ready;
   assign w_head_valid = (r_count != '0);
   assign w_head_instr = r_instr_mem[r_rd_ptr];
   assign w_head_pc    = r_pc_mem[r_rd_ptr];
   assign w_head       = decode_fields(w_head_instr);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr (w_head_instr),
      .o_imm   (w_head_imm)
   );

   // Load in the output stage whose rd feeds a source of the queue head
   always_comb begin
      w_hazard = 1'b0;
      if (HAZARD_EN && r_de_valid && w_head_valid &&
          (r_de_decoded.opcode == OPC_LOAD) && (r_de_decoded.rd != 5'd0)) begin
         if (fmt_uses_rs1(w_head.fmt) && (w_head.rs1 == r_de_decoded.rd))
            w_hazard = 1'b1;
         if (fmt_uses_rs2(w_head.fmt) && (w_head.rs2 == r_de_decoded.rd))
            w_hazard = 1'b1;
      end
   end

   assign w_advance = w_head_valid && (!r_de_valid || bus.de_ready) && !w_hazard;

   // Queue storage; contents are don't-care while the occupancy is zero
   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_push) begin
         r_instr_mem[r_wr_ptr] <= bus.fd_instr;
         r_pc_mem[r_wr_ptr]    <= bus.fd_pc;
      end
   end

   // Queue pointers and occupancy; flush empties the queue outright
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_advance)
            r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_push, w_advance})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Output stage: load on advance, hold under backpressure, else drain
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_de_valid   <= 1'b0;
         r_de_decoded <= '0;
         r_de_pc      <= '0;
         r_de_rs1_val <= '0;
         r_de_rs2_val <= '0;
         r_de_imm     <= '0;
         r_de_illegal <= 1'b0;
      end else if (flush) begin
         r_de_valid <= 1'b0;
      end else if (w_advance) begin
         r_de_valid   <= 1'b1;
         r_de_decoded <= w_head;
         r_de_pc      <= w_head_pc;
         r_de_rs1_val <= rf_rs1_data;
         r_de_rs2_val <= rf_rs2_data;
         r_de_imm     <= w_head_imm;
         r_de_illegal <= !opcode_legal(w_head.opcode);
      end else if (bus.de_ready) begin
         r_de_valid <= 1'b0;
      end
   end

   // Count bubble cycles caused by load-use hazards, saturating
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_count <= '0;
      end else if (!flush && w_hazard && bus.de_ready && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign bus.fd_ready   = w_fd_ready;
   assign bus.de_valid   = r_de_valid;
   assign bus.de_decoded = r_de_decoded;
   assign bus.de_pc      = r_de_pc;
   assign bus.de_rs1_val = r_de_rs1_val;
   assign bus.de_rs2_val = r_de_rs2_val;
   assign bus.de_imm     = r_de_imm;
   assign bus.de_illegal = r_de_illegal;
   assign rf_rs1_addr    = w_head.rs1;
   assign rf_rs2_addr    = w_head.rs2;
   assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: table of single-instruction decodes plus
// hand-written sequences for load-use stall, backpressure, flush and reset.
module tb_decode_pipe;
   import riscv_pkg::*;

   localparam int unsigned XLEN = 32;

   logic clk;
   logic rst_n;
   logic flush;
   logic [4:0]  rs1a0, rs2a0, rs1a1, rs2a1;
   logic [31:0] rs1d0, rs2d0, rs1d1, rs2d1;
   logic [15:0] stall0, stall1;

   int checks;
   int failures;

   decode_pipe_if #(.XLEN(XLEN)) bus0 ();
   decode_pipe_if #(.XLEN(XLEN)) bus1 ();

   // Second instance (no hazard detection) sees identical stimulus
   assign bus1.fd_valid = bus0.fd_valid;
   assign bus1.fd_instr = bus0.fd_instr;
   assign bus1.fd_pc    = bus0.fd_pc;
   assign bus1.de_ready = bus0.de_ready;

   function automatic logic [31:0] rf_val(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : (({27'd0, a} + 32'd1) << 4);
   endfunction

   assign rs1d0 = rf_val(rs1a0);
   assign rs2d0 = rf_val(rs2a0);
   assign rs1d1 = rf_val(rs1a1);
   assign rs2d1 = rf_val(rs2a1);

   decode_pipe #(.XLEN(XLEN), .QDEPTH(2), .HAZARD_EN(1'b1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus0.slave),
      .flush       (flush),
      .rf_rs1_addr (rs1a0),
      .rf_rs2_addr (rs2a0),
      .rf_rs1_data (rs1d0),
      .rf_rs2_data (rs2d0),
      .stall_count (stall0)
   );

   decode_pipe #(.XLEN(XLEN), .QDEPTH(2), .HAZARD_EN(1'b0)) u_dut_nohz (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus1.slave),
      .flush       (flush),
      .rf_rs1_addr (rs1a1),
      .rf_rs2_addr (rs2a1),
      .rf_rs1_data (rs1d1),
      .rf_rs2_data (rs2d1),
      .stall_count (stall1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
      logic [31:0] rs1v;
      logic [31:0] rs2v;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
      bus0.fd_valid = 1'b1;
      bus0.fd_instr = instr;
      bus0.fd_pc    = pc;
   endtask

   localparam logic [31:0] I_LW  = 32'h0000A303; // lw  x6, 0(x1)
   localparam logic [31:0] I_ADD = 32'h002303B3; // add x7, x6, x2
   localparam logic [31:0] I_ADDI = 32'h00A00293; // addi x5, x0, 10

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      bus0.fd_valid = 1'b0;
      bus0.fd_instr = '0;
      bus0.fd_pc    = '0;
      bus0.de_ready = 1'b1;

      vecs[0] = '{32'h00A00293, 32'h100, 7'h13, 5'd5,  5'd0,  5'd10, 32'h0000000A, 1'b0, 32'h0,   32'hB0};
      vecs[1] = '{32'hFFF08093, 32'h104, 7'h13, 5'd1,  5'd1,  5'd31, 32'hFFFFFFFF, 1'b0, 32'h20,  32'h200};
      vecs[2] = '{32'hFE20AE23, 32'h108, 7'h23, 5'd28, 5'd1,  5'd2,  32'hFFFFFFFC, 1'b0, 32'h20,  32'h30};
      vecs[3] = '{32'hFE208CE3, 32'h10C, 7'h63, 5'd25, 5'd1,  5'd2,  32'hFFFFFFF8, 1'b0, 32'h20,  32'h30};
      vecs[4] = '{32'h123451B7, 32'h110, 7'h37, 5'd3,  5'd8,  5'd3,  32'h12345000, 1'b0, 32'h90,  32'h40};
      vecs[5] = '{32'hFFDFF0EF, 32'h114, 7'h6F, 5'd1,  5'd31, 5'd29, 32'hFFFFFFFC, 1'b0, 32'h200, 32'h1E0};
      vecs[6] = '{32'h0000007F, 32'h118, 7'h7F, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1, 32'h0,   32'h0};
      vecs[7] = '{32'h002303B3, 32'h11C, 7'h33, 5'd7,  5'd6,  5'd2,  32'h00000000, 1'b0, 32'h70,  32'h30};

      // Reset state
      tick();
      tick();
      chk("rst_fd_ready", bus0.fd_ready, 1);
      chk("rst_de_valid", bus0.de_valid, 0);
      chk("rst_de_pc", bus0.de_pc, 0);
      chk("rst_de_imm", bus0.de_imm, 0);
      chk("rst_de_illegal", bus0.de_illegal, 0);
      chk("rst_stall", stall0, 0);
      rst_n = 1'b1;

      // Single-instruction decode table
      for (int i = 0; i < 8; i++) begin
         push_one(vecs[i].instr, vecs[i].pc);
         tick();
         bus0.fd_valid = 1'b0;
         chk($sformatf("v%0d_pre_valid", i), bus0.de_valid, 0);
         tick();
         chk($sformatf("v%0d_valid", i),   bus0.de_valid, 1);
         chk($sformatf("v%0d_opcode", i),  bus0.de_decoded.opcode, vecs[i].opc);
         chk($sformatf("v%0d_rd", i),      bus0.de_decoded.rd, vecs[i].rd);
         chk($sformatf("v%0d_rs1", i),     bus0.de_decoded.rs1, vecs[i].rs1);
         chk($sformatf("v%0d_rs2", i),     bus0.de_decoded.rs2, vecs[i].rs2);
         chk($sformatf("v%0d_imm", i),     bus0.de_imm, vecs[i].imm);
         chk($sformatf("v%0d_illegal", i), bus0.de_illegal, vecs[i].ill);
         chk($sformatf("v%0d_pc", i),      bus0.de_pc, vecs[i].pc);
         chk($sformatf("v%0d_rs1_val", i), bus0.de_rs1_val, vecs[i].rs1v);
         chk($sformatf("v%0d_rs2_val", i), bus0.de_rs2_val, vecs[i].rs2v);
         tick();
         chk($sformatf("v%0d_drain", i), bus0.de_valid, 0);
      end
      chk("tbl_stall", stall0, 0);

      // Load-use: LW x6 then ADD using x6 back-to-back
      push_one(I_LW, 32'h300);
      tick();
      push_one(I_ADD, 32'h304);
      tick();
      bus0.fd_valid = 1'b0;
      chk("hz_lw_valid", bus0.de_valid, 1);
      chk("hz_lw_opcode", bus0.de_decoded.opcode, 7'h03);
      chk("hz_lw_rd", bus0.de_decoded.rd, 6);
      chk("nohz_lw_valid", bus1.de_valid, 1);
      tick();
      chk("hz_bubble", bus0.de_valid, 0);
      chk("hz_stall1", stall0, 1);
      chk("nohz_add_valid", bus1.de_valid, 1);
      chk("nohz_add_opcode", bus1.de_decoded.opcode, 7'h33);
      chk("nohz_stall", stall1, 0);
      tick();
      chk("hz_add_valid", bus0.de_valid, 1);
      chk("hz_add_opcode", bus0.de_decoded.opcode, 7'h33);
      chk("hz_add_rs1", bus0.de_decoded.rs1, 6);
      chk("hz_add_rs2", bus0.de_decoded.rs2, 2);
      chk("hz_add_rs1_val", bus0.de_rs1_val, 32'h70);
      chk("hz_add_rs2_val", bus0.de_rs2_val, 32'h30);
      chk("hz_add_pc", bus0.de_pc, 32'h304);
      chk("hz_stall_hold", stall0, 1);
      chk("nohz_drain", bus1.de_valid, 0);
      tick();
      chk("hz_drain", bus0.de_valid, 0);

      // Backpressure: QDEPTH+1 accepted, then fd_ready low and outputs held
      bus0.de_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push_one(I_ADDI, 32'h200 + 32'(4 * k));
         chk($sformatf("bp_ready%0d", k), bus0.fd_ready, 1);
         tick();
      end
      push_one(I_ADDI, 32'h20C);
      chk("bp_full", bus0.fd_ready, 0);
      chk("bp_valid", bus0.de_valid, 1);
      chk("bp_pc0", bus0.de_pc, 32'h200);
      tick();
      chk("bp_full_hold", bus0.fd_ready, 0);
      chk("bp_valid_hold", bus0.de_valid, 1);
      chk("bp_pc0_hold", bus0.de_pc, 32'h200);
      bus0.fd_valid = 1'b0;
      bus0.de_ready = 1'b1;
      tick();
      chk("bp_pc1", bus0.de_pc, 32'h204);
      chk("bp_v1", bus0.de_valid, 1);
      tick();
      chk("bp_pc2", bus0.de_pc, 32'h208);
      chk("bp_v2", bus0.de_valid, 1);
      tick();
      chk("bp_done", bus0.de_valid, 0);

      // Flush with full queue and a pending push
      bus0.de_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push_one(I_ADDI, 32'h400 + 32'(4 * k));
         tick();
      end
      chk("fl_full", bus0.fd_ready, 0);
      push_one(I_ADDI, 32'h40C);
      flush = 1'b1;
      bus0.de_ready = 1'b1;
      tick();
      flush = 1'b0;
      bus0.fd_valid = 1'b0;
      chk("fl_valid", bus0.de_valid, 0);
      chk("fl_empty", bus0.fd_ready, 1);
      chk("fl_stall", stall0, 1);
      tick();
      chk("fl_nothing1", bus0.de_valid, 0);
      tick();
      chk("fl_nothing2", bus0.de_valid, 0);

      // Reset while a load-use stall is pending
      push_one(I_LW, 32'h500);
      tick();
      push_one(I_ADD, 32'h504);
      tick();
      bus0.fd_valid = 1'b0;
      chk("rs_lw_valid", bus0.de_valid, 1);
      rst_n = 1'b0;
      tick();
      chk("rs_fd_ready", bus0.fd_ready, 1);
      chk("rs_de_valid", bus0.de_valid, 0);
      chk("rs_de_pc", bus0.de_pc, 0);
      chk("rs_de_rs1_val", bus0.de_rs1_val, 0);
      chk("rs_de_decoded", bus0.de_decoded, 0);
      chk("rs_de_imm", bus0.de_imm, 0);
      chk("rs_de_illegal", bus0.de_illegal, 0);
      chk("rs_stall", stall0, 0);
      rst_n = 1'b1;
      tick();
      chk("rs_after1", bus0.de_valid, 0);
      tick();
      chk("rs_after2", bus0.de_valid, 0);
      chk("rs_stall_after", stall0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
